// File: rtl/pxs_ball_tracker_pkg.sv
// pxs_ball_tracker_pkg: pixel-stream field layout, raster defaults and tracker FSM states.
package pxs_ball_tracker_pkg;
  localparam int XC_HI = 25, XC_LO = 16;
  localparam int YC_HI = 15, YC_LO = 6;
  localparam int RGB_HI = 2, RGB_LO = 0;
  localparam int unsigned PXS_COLS = 640;
  localparam int unsigned PXS_ROWS = 480;
  typedef enum logic [1:0] {WAIT_SOF, ACCUM, REPORT} state_t;
  function automatic logic [9:0] centre(input logic [9:0] lo, input logic [9:0] hi);
    logic [10:0] s;
    s = {1'b0, lo} + {1'b0, hi};
    return s[10:1];
  endfunction
endpackage

// File: rtl/pxs_ball_tracker_if.sv
// pxs_ball_tracker_if: pixel stream in/out plus the per-frame object report.
interface pxs_ball_tracker_if;
  logic [25:0] RGBStr_i, RGBStr_o;
  logic obj_valid, obj_found, obj_lost;
  logic [9:0] obj_xmin, obj_xmax, obj_ymin, obj_ymax, obj_xc, obj_yc;
  logic [18:0] obj_count;
  logic signed [10:0] obj_vx, obj_vy;
  modport master (output RGBStr_i, input RGBStr_o, obj_valid, obj_found, obj_lost,
                  obj_xmin, obj_xmax, obj_ymin, obj_ymax, obj_xc, obj_yc, obj_count, obj_vx, obj_vy);
  modport slave (input RGBStr_i, output RGBStr_o, obj_valid, obj_found, obj_lost,
                 obj_xmin, obj_xmax, obj_ymin, obj_ymax, obj_xc, obj_yc, obj_count, obj_vx, obj_vy);
endinterface

// File: rtl/pxs_bbox_accum.sv
// pxs_bbox_accum: per-frame min/max box and saturating match count.
module pxs_bbox_accum (
  input  logic        px_clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        init,
  input  logic        match,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic [9:0]  xmin,
  output logic [9:0]  xmax,
  output logic [9:0]  ymin,
  output logic [9:0]  ymax,
  output logic [18:0] count
);
  logic [9:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [9:0] bxmin, bxmax, bymin, bymax;
  logic [18:0] count_q, count_d, bcount;
  // init starts from an empty box so the pixel presented with it is applied on top
  always_comb begin
    bxmin = (clear || init) ? 10'h3FF : xmin_q;
    bxmax = (clear || init) ? 10'h000 : xmax_q;
    bymin = (clear || init) ? 10'h3FF : ymin_q;
    bymax = (clear || init) ? 10'h000 : ymax_q;
    bcount = (clear || init) ? 19'd0 : count_q;
    xmin_d = (match && x < bxmin) ? x : bxmin;
    xmax_d = (match && x > bxmax) ? x : bxmax;
    ymin_d = (match && y < bymin) ? y : bymin;
    ymax_d = (match && y > bymax) ? y : bymax;
    count_d = (match && !(&bcount)) ? bcount + 19'd1 : bcount;
  end
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      xmin_q <= 10'h3FF;
      xmax_q <= 10'h000;
      ymin_q <= 10'h3FF;
      ymax_q <= 10'h000;
      count_q <= 19'd0;
    end else begin
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
      count_q <= count_d;
    end
  end
  assign xmin = xmin_q;
  assign xmax = xmax_q;
  assign ymin = ymin_q;
  assign ymax = ymax_q;
  assign count = count_q;
endmodule

// File: rtl/pxs_ball_tracker.sv
// pxs_ball_tracker: per-frame colour-blob tracker reporting box, centre, count and velocity,
// with optional outline of the last found box drawn onto the passed-through stream.
module pxs_ball_tracker import pxs_ball_tracker_pkg::*; #(
  parameter logic [2:0]  TARGET_RGB  = 3'b101,
  parameter logic [2:0]  BOX_RGB     = 3'b010,
  parameter bit          DRAW_BOX    = 1'b1,
  parameter int unsigned MIN_PIXELS  = 4,
  parameter int unsigned LOST_FRAMES = 8,
  parameter int unsigned VISIBLECOLS = PXS_COLS,
  parameter int unsigned VISIBLEROWS = PXS_ROWS
) (
  input logic px_clk,
  input logic rst_n,
  pxs_ball_tracker_if.slave b
);
  localparam int MW = $clog2(LOST_FRAMES + 1);
  localparam logic [MW-1:0] LOST_C = MW'(LOST_FRAMES);
  localparam logic [18:0] MIN_C = 19'(MIN_PIXELS);
  localparam logic [9:0] COLS_C = 10'(VISIBLECOLS);
  localparam logic [9:0] ROWS_C = 10'(VISIBLEROWS);
  logic [9:0] x, y, nxc, nyc;
  logic [2:0] rgb;
  logic sof, eof, match, rep, found, upd, in_x, in_y, on_box;
  logic acc_init, acc_clear, acc_match;
  logic [9:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  logic [18:0] acc_count;
  state_t state_q, state_d;
  logic valid_q, valid_d, found_q, found_d;
  logic [9:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [9:0] xc_q, xc_d, yc_q, yc_d;
  logic [18:0] count_q, count_d;
  logic signed [10:0] vx_q, vx_d, vy_q, vy_d;
  logic [MW-1:0] miss_q, miss_d;
  logic [25:0] out_q, out_d;
  assign x = b.RGBStr_i[XC_HI:XC_LO];
  assign y = b.RGBStr_i[YC_HI:YC_LO];
  assign rgb = b.RGBStr_i[RGB_HI:RGB_LO];
  assign match = (x < COLS_C) && (y < ROWS_C) && (rgb == TARGET_RGB);
  assign sof = (x == 10'd0) && (y == 10'd0);
  assign eof = (x == COLS_C - 10'd1) && (y == ROWS_C - 10'd1);
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_SOF;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_SOF: state_d = sof ? ACCUM : WAIT_SOF;
      ACCUM:    state_d = eof ? REPORT : ACCUM;
      default:  state_d = ACCUM;
    endcase
  end
  // a sof pixel restarts the frame from any state, so a restarted stream never mixes frames
  always_comb begin
    acc_init = sof;
    acc_clear = (state_q == WAIT_SOF) && !sof;
    acc_match = match && (sof || state_q == ACCUM);
    rep = state_q == REPORT;
    found = acc_count >= MIN_C;
    upd = rep && found;
    nxc = centre(acc_xmin, acc_xmax);
    nyc = centre(acc_ymin, acc_ymax);
    valid_d = rep;
    found_d = rep ? found : found_q;
    count_d = rep ? acc_count : count_q;
    xmin_d = upd ? acc_xmin : xmin_q;
    xmax_d = upd ? acc_xmax : xmax_q;
    ymin_d = upd ? acc_ymin : ymin_q;
    ymax_d = upd ? acc_ymax : ymax_q;
    xc_d = upd ? nxc : xc_q;
    yc_d = upd ? nyc : yc_q;
    vx_d = upd ? (found_q ? $signed({1'b0, nxc}) - $signed({1'b0, xc_q}) : 11'sd0) : vx_q;
    vy_d = upd ? (found_q ? $signed({1'b0, nyc}) - $signed({1'b0, yc_q}) : 11'sd0) : vy_q;
    miss_d = !rep ? miss_q : found ? '0 : (miss_q >= LOST_C) ? miss_q : miss_q + 1'b1;
    in_x = (x >= xmin_q) && (x <= xmax_q);
    in_y = (y >= ymin_q) && (y <= ymax_q);
    on_box = (in_x && (y == ymin_q || y == ymax_q)) || (in_y && (x == xmin_q || x == xmax_q));
    out_d = b.RGBStr_i;
    out_d[RGB_HI:RGB_LO] = (DRAW_BOX && found_q && on_box) ? BOX_RGB : rgb;
  end
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      found_q <= 1'b0;
      count_q <= '0;
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
      xc_q <= '0;
      yc_q <= '0;
      vx_q <= '0;
      vy_q <= '0;
      miss_q <= '0;
      out_q <= '0;
    end else begin
      valid_q <= valid_d;
      found_q <= found_d;
      count_q <= count_d;
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
      xc_q <= xc_d;
      yc_q <= yc_d;
      vx_q <= vx_d;
      vy_q <= vy_d;
      miss_q <= miss_d;
      out_q <= out_d;
    end
  end
  pxs_bbox_accum u_accum (
    .px_clk(px_clk), .rst_n(rst_n), .clear(acc_clear), .init(acc_init), .match(acc_match),
    .x(x), .y(y), .xmin(acc_xmin), .xmax(acc_xmax), .ymin(acc_ymin), .ymax(acc_ymax),
    .count(acc_count)
  );
  assign b.RGBStr_o = out_q;
  assign b.obj_valid = valid_q;
  assign b.obj_found = found_q;
  assign b.obj_count = count_q;
  assign b.obj_xmin = xmin_q;
  assign b.obj_xmax = xmax_q;
  assign b.obj_ymin = ymin_q;
  assign b.obj_ymax = ymax_q;
  assign b.obj_xc = xc_q;
  assign b.obj_yc = yc_q;
  assign b.obj_vx = vx_q;
  assign b.obj_vy = vy_q;
  assign b.obj_lost = miss_q >= LOST_C;
endmodule

// File: tb/tb_pxs_ball_tracker.sv
// tb_pxs_ball_tracker: directed frames (sof, target pixels, eof) with hand-computed reports.
module tb_pxs_ball_tracker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  localparam logic [2:0] TGT = 3'b101;
  pxs_ball_tracker_if bus ();
  pxs_ball_tracker dut (.px_clk(clk), .rst_n(rst_n), .b(bus));
  always #5 clk = ~clk;
  function automatic logic [25:0] pk(input int x, input int y, input logic [2:0] s, input logic [2:0] c);
    return {10'(x), 10'(y), s, c};
  endfunction
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic px(input int x, input int y, input logic [2:0] c, input logic [2:0] s = 3'b000);
    @(negedge clk);
    bus.RGBStr_i = pk(x, y, s, c);
  endtask
  task automatic end_frame(input logic [2:0] c);
    px(639, 479, c);
    px(700, 500, 3'b000);
    chk("valid_early", bus.obj_valid, 0);
    px(700, 500, 3'b000);
    chk("valid_pulse", bus.obj_valid, 1);
    @(negedge clk);
    chk("valid_drop", bus.obj_valid, 0);
  endtask
  task automatic block(input int x0, input int y0);
    for (int yy = y0; yy < y0 + 16; yy++)
      for (int xx = x0; xx < x0 + 16; xx++) px(xx, yy, TGT);
  endtask
  task automatic frame_block(input int x0, input int y0);
    px(0, 0, 3'b000);
    block(x0, y0);
    end_frame(3'b000);
  endtask
  task automatic report(input string t, input int xmin, input int xmax, input int ymin, input int ymax,
                        input int xc, input int yc, input int cnt, input int vx, input int vy,
                        input int found, input int lost);
    chk({t, ".xmin"}, bus.obj_xmin, xmin);
    chk({t, ".xmax"}, bus.obj_xmax, xmax);
    chk({t, ".ymin"}, bus.obj_ymin, ymin);
    chk({t, ".ymax"}, bus.obj_ymax, ymax);
    chk({t, ".xc"}, bus.obj_xc, xc);
    chk({t, ".yc"}, bus.obj_yc, yc);
    chk({t, ".count"}, bus.obj_count, cnt);
    chk({t, ".vx"}, bus.obj_vx, vx);
    chk({t, ".vy"}, bus.obj_vy, vy);
    chk({t, ".found"}, bus.obj_found, found);
    chk({t, ".lost"}, bus.obj_lost, lost);
  endtask
  task automatic all_zero(input string t);
    chk({t, ".out"}, bus.RGBStr_o, 0);
    chk({t, ".valid"}, bus.obj_valid, 0);
    report(t, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    bus.RGBStr_i = '0;
    repeat (2) @(negedge clk);
    all_zero("reset");
    rst_n = 1'b1;
    frame_block(100, 200);
    report("f1", 100, 115, 200, 215, 107, 207, 256, 0, 0, 1, 0);
    frame_block(103, 202);
    report("f2", 103, 118, 202, 217, 110, 209, 256, 3, 2, 1, 0);
    frame_block(98, 201);
    report("f3", 98, 113, 201, 216, 105, 208, 256, -5, -1, 1, 0);
    px(0, 0, TGT);
    end_frame(TGT);
    report("corners", 98, 113, 201, 216, 105, 208, 2, -5, -1, 0, 0);
    frame_block(100, 200);
    report("f5", 100, 115, 200, 215, 107, 207, 256, 0, 0, 1, 0);
    for (int f = 1; f <= 9; f++) begin
      px(0, 0, 3'b000);
      end_frame(3'b000);
      chk($sformatf("empty%0d.found", f), bus.obj_found, 0);
      chk($sformatf("empty%0d.count", f), bus.obj_count, 0);
      chk($sformatf("empty%0d.lost", f), bus.obj_lost, (f >= 8) ? 1 : 0);
    end
    chk("empty.xc_held", bus.obj_xc, 107);
    frame_block(100, 200);
    report("refound", 100, 115, 200, 215, 107, 207, 256, 0, 0, 1, 0);
    px(100, 205, 3'b111, 3'b110);
    @(negedge clk);
    chk("draw_left", bus.RGBStr_o, pk(100, 205, 3'b110, 3'b010));
    px(107, 200, 3'b111, 3'b011);
    @(negedge clk);
    chk("draw_top", bus.RGBStr_o, pk(107, 200, 3'b011, 3'b010));
    px(115, 215, 3'b000, 3'b001);
    @(negedge clk);
    chk("draw_corner", bus.RGBStr_o, pk(115, 215, 3'b001, 3'b010));
    px(107, 207, 3'b011, 3'b100);
    @(negedge clk);
    chk("draw_inside", bus.RGBStr_o, pk(107, 207, 3'b100, 3'b011));
    px(99, 205, 3'b111, 3'b000);
    @(negedge clk);
    chk("draw_outside", bus.RGBStr_o, pk(99, 205, 3'b000, 3'b111));
    px(116, 200, 3'b110, 3'b000);
    px(117, 200, 3'b001, 3'b000);
    chk("latency1", bus.RGBStr_o, pk(116, 200, 3'b000, 3'b110));
    px(0, 0, 3'b000);
    for (int xx = 300; xx <= 320; xx++) px(xx, 240, TGT);
    #2 rst_n = 1'b0;
    #1 all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int xx = 321; xx < 340; xx++) px(xx, 240, TGT);
    px(639, 479, TGT);
    for (int i = 0; i < 4; i++) begin
      px(700, 500, 3'b000);
      chk("postreset.novalid", bus.obj_valid, 0);
    end
    frame_block(50, 60);
    report("postreset", 50, 65, 60, 75, 57, 67, 256, 0, 0, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
